// File: rtl/alu_ctrl_issue_if.sv
// Decode-request / ALU-op handshake bundle between the issue stage and the ALU control block.
interface alu_ctrl_issue_if #(
  parameter int OPCW = 11
);
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      in_aluop;
  logic [OPCW-1:0] in_opcode;
  logic            out_valid;
  logic            out_ready;
  logic [3:0]      out_op;
  logic            out_illegal;

  modport master (
    output in_valid, in_aluop, in_opcode, out_ready,
    input  in_ready, out_valid, out_op, out_illegal
  );

  modport slave (
    input  in_valid, in_aluop, in_opcode, out_ready,
    output in_ready, out_valid, out_op, out_illegal
  );
endinterface

// File: rtl/alu_ctrl_issue.sv
// ALU control decoder with a two-entry (output + skid) issue buffer and a saturating
// illegal-request counter; in_ready is registered so upstream never sees out_ready combinationally.
module alu_ctrl_issue #(
  parameter int OPCW = 11,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  alu_ctrl_issue_if.slave bus,
  output logic [CNTW-1:0] illegal_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_ORR  = 4'b0001;
  localparam logic [3:0] OP_PASS = 4'b0111;
  localparam logic [3:0] OP_ILL  = 4'b1111;

  state_e          state_q;
  logic            in_ready_q;
  logic            out_valid_q;
  logic [3:0]      out_op_q;
  logic            out_ill_q;
  logic [3:0]      skid_op_q;
  logic            skid_ill_q;
  logic [CNTW-1:0] cnt_q;

  logic [3:0] dec_op_d;
  logic       dec_ill_d;
  logic       accept;
  logic       drain;

  assign accept = bus.in_valid && in_ready_q;
  assign drain  = out_valid_q && bus.out_ready;

  // NOTE: every output of this block gets a default first, so no path leaves a latch.
  always_comb begin
    dec_op_d  = OP_ILL;
    dec_ill_d = 1'b1;
    unique case (bus.in_aluop)
      2'b00: begin dec_op_d = OP_ADD;  dec_ill_d = 1'b0; end
      2'b01: begin dec_op_d = OP_PASS; dec_ill_d = 1'b0; end
      2'b10: begin
        if (bus.in_opcode == OPCW'(11'b10001011000)) begin
          dec_op_d = OP_ADD; dec_ill_d = 1'b0;
        end else if (bus.in_opcode == OPCW'(11'b11001011000)) begin
          dec_op_d = OP_SUB; dec_ill_d = 1'b0;
        end else if (bus.in_opcode == OPCW'(11'b10001010000)) begin
          dec_op_d = OP_AND; dec_ill_d = 1'b0;
        end else if (bus.in_opcode == OPCW'(11'b10101010000)) begin
          dec_op_d = OP_ORR; dec_ill_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // NOTE: non-blocking assignments throughout, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_op_q    <= OP_AND;
      out_ill_q   <= 1'b0;
      // NOTE: skid data is cleared too, so a discarded entry can never resurface after reset.
      skid_op_q   <= '0;
      skid_ill_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      if (accept && dec_ill_d && (cnt_q != '1)) cnt_q <= cnt_q + CNTW'(1);

      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_q     <= ONE;
            out_valid_q <= 1'b1;
            out_op_q    <= dec_op_d;
            out_ill_q   <= dec_ill_d;
          end
        end
        ONE: begin
          if (accept && !drain) begin
            state_q    <= TWO;
            in_ready_q <= 1'b0;
            skid_op_q  <= dec_op_d;
            skid_ill_q <= dec_ill_d;
          end else if (accept && drain) begin
            out_op_q  <= dec_op_d;
            out_ill_q <= dec_ill_d;
          end else if (drain) begin
            state_q     <= EMPTY;
            out_valid_q <= 1'b0;
            out_op_q    <= OP_AND;
            out_ill_q   <= 1'b0;
          end
        end
        TWO: begin
          if (drain) begin
            state_q    <= ONE;
            in_ready_q <= 1'b1;
            out_op_q   <= skid_op_q;
            out_ill_q  <= skid_ill_q;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_op      = out_op_q;
  assign bus.out_illegal = out_ill_q;
  assign illegal_cnt     = cnt_q;

endmodule

// File: tb/tb_alu_ctrl_issue.sv
// Self-checking bench: queue-based reference model compared every cycle, plus directed
// sequences with literal expectations, then randomized traffic with resets sprinkled in.
module tb_alu_ctrl_issue;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_ctrl_issue_if #(.OPCW(11)) bus ();
  alu_ctrl_issue_if #(.OPCW(11)) bus2 ();
  logic [15:0] illegal_cnt;
  logic [1:0]  illegal_cnt2;

  alu_ctrl_issue #(.OPCW(11), .CNTW(16)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .illegal_cnt(illegal_cnt)
  );

  alu_ctrl_issue #(.OPCW(11), .CNTW(2)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2.slave), .illegal_cnt(illegal_cnt2)
  );

  assign bus2.in_valid  = bus.in_valid;
  assign bus2.in_aluop  = bus.in_aluop;
  assign bus2.in_opcode = bus.in_opcode;
  assign bus2.out_ready = bus.out_ready;

  localparam logic [10:0] OPC_ADD = 11'b10001011000;
  localparam logic [10:0] OPC_SUB = 11'b11001011000;
  localparam logic [10:0] OPC_AND = 11'b10001010000;
  localparam logic [10:0] OPC_ORR = 11'b10101010000;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list of decoded entries, capacity two.
  typedef struct {
    logic [3:0] op;
    logic       ill;
  } ent_t;

  ent_t mq[$];
  int   mcnt  = 0;
  int   mcnt2 = 0;
  bit   armed = 1'b0;
  bit   acc_last = 1'b0;

  function automatic ent_t ref_decode(input logic [1:0] a, input logic [10:0] o);
    ent_t r;
    r = '{op: 4'b1111, ill: 1'b1};
    if (a == 2'b00) r = '{op: 4'b0010, ill: 1'b0};
    if (a == 2'b01) r = '{op: 4'b0111, ill: 1'b0};
    if (a == 2'b10) begin
      if (o == OPC_ADD) r = '{op: 4'b0010, ill: 1'b0};
      if (o == OPC_SUB) r = '{op: 4'b0110, ill: 1'b0};
      if (o == OPC_AND) r = '{op: 4'b0000, ill: 1'b0};
      if (o == OPC_ORR) r = '{op: 4'b0001, ill: 1'b0};
    end
    return r;
  endfunction

  always @(posedge clk) begin
    bit   rdy, drn, acc;
    ent_t e;
    if (rst) begin
      mq.delete();
      mcnt     = 0;
      mcnt2    = 0;
      armed    = 1'b1;
      acc_last = 1'b0;
    end else if (armed) begin
      rdy = (mq.size() < 2);
      drn = (mq.size() > 0) && bus.out_ready;
      acc = bus.in_valid && rdy;
      if (drn) void'(mq.pop_front());
      if (acc) begin
        e = ref_decode(bus.in_aluop, bus.in_opcode);
        mq.push_back(e);
        if (e.ill) begin
          if (mcnt < 65535) mcnt++;
          if (mcnt2 < 3) mcnt2++;
        end
      end
      acc_last = acc;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      check("in_ready",     32'(bus.in_ready),     32'(mq.size() < 2));
      check("out_valid",    32'(bus.out_valid),    32'(mq.size() > 0));
      check("out_op",       32'(bus.out_op),       32'((mq.size() > 0) ? mq[0].op : 4'b0000));
      check("out_illegal",  32'(bus.out_illegal),  32'((mq.size() > 0) ? mq[0].ill : 1'b0));
      check("illegal_cnt",  32'(illegal_cnt),      32'(mcnt));
      check("illegal_cnt2", 32'(illegal_cnt2),     32'(mcnt2));
      check("out_op2",      32'(bus2.out_op),      32'(bus.out_op));
    end
  end

  task automatic drive(input bit v, input logic [1:0] a, input logic [10:0] o, input bit ordy);
    bus.in_valid  = v;
    bus.in_aluop  = a;
    bus.in_opcode = o;
    bus.out_ready = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit          v;
    logic [1:0]  a;
    logic [10:0] o;
    drive(1'b0, 2'b00, 11'd0, 1'b0);
    rst = 1'b1;
    tick(); tick();
    check("rst_in_ready",  32'(bus.in_ready),    32'd1);
    check("rst_out_valid", 32'(bus.out_valid),   32'd0);
    check("rst_out_op",    32'(bus.out_op),      32'd0);
    check("rst_illegal",   32'(bus.out_illegal), 32'd0);
    check("rst_cnt",       32'(illegal_cnt),     32'd0);

    // SUB through an empty buffer: visible right after the accepting edge.
    rst = 1'b0;
    drive(1'b1, 2'b10, OPC_SUB, 1'b1);
    tick();
    check("sub_valid", 32'(bus.out_valid),   32'd1);
    check("sub_op",    32'(bus.out_op),      32'b0110);
    check("sub_ill",   32'(bus.out_illegal), 32'd0);
    drive(1'b0, 2'b00, 11'd0, 1'b1);
    tick();
    check("sub_drained", 32'(bus.out_valid), 32'd0);

    // Back-to-back mem / branch / AND at full throughput.
    drive(1'b1, 2'b00, 11'd0, 1'b1);
    tick();
    check("b2b_op0", 32'(bus.out_op), 32'b0010);
    check("b2b_rdy0", 32'(bus.in_ready), 32'd1);
    drive(1'b1, 2'b01, 11'd0, 1'b1);
    tick();
    check("b2b_op1", 32'(bus.out_op), 32'b0111);
    check("b2b_rdy1", 32'(bus.in_ready), 32'd1);
    drive(1'b1, 2'b10, OPC_AND, 1'b1);
    tick();
    check("b2b_op2", 32'(bus.out_op), 32'b0000);
    check("b2b_vld2", 32'(bus.out_valid), 32'd1);
    check("b2b_rdy2", 32'(bus.in_ready), 32'd1);
    drive(1'b0, 2'b00, 11'd0, 1'b1);
    tick();

    // Backpressure: ADD, ORR fill the buffer, SUB waits and keeps order.
    drive(1'b1, 2'b10, OPC_ADD, 1'b0);
    tick();
    check("bp_op_a", 32'(bus.out_op), 32'b0010);
    drive(1'b1, 2'b10, OPC_ORR, 1'b0);
    tick();
    check("bp_full_rdy", 32'(bus.in_ready), 32'd0);
    drive(1'b1, 2'b10, OPC_SUB, 1'b0);
    tick();
    check("bp_hold_op",  32'(bus.out_op),   32'b0010);
    check("bp_hold_rdy", 32'(bus.in_ready), 32'd0);
    drive(1'b1, 2'b10, OPC_SUB, 1'b1);
    tick();
    check("bp_op_o", 32'(bus.out_op), 32'b0001);
    tick();
    check("bp_op_s", 32'(bus.out_op), 32'b0110);
    drive(1'b0, 2'b00, 11'd0, 1'b1);
    tick();
    check("bp_empty", 32'(bus.out_valid), 32'd0);

    // Illegal requests and counter saturation on the narrow instance.
    drive(1'b1, 2'b11, 11'd0, 1'b1);
    tick();
    check("ill_op0",  32'(bus.out_op),      32'b1111);
    check("ill_ill0", 32'(bus.out_illegal), 32'd1);
    drive(1'b1, 2'b10, 11'd0, 1'b1);
    tick();
    check("ill_op1",  32'(bus.out_op),      32'b1111);
    check("ill_ill1", 32'(bus.out_illegal), 32'd1);
    check("ill_cnt2", 32'(illegal_cnt),     32'd2);
    drive(1'b1, 2'b11, 11'd0, 1'b1);
    tick(); tick(); tick();
    check("ill_cnt5",  32'(illegal_cnt),  32'd5);
    check("ill_sat",   32'(illegal_cnt2), 32'd3);
    drive(1'b0, 2'b00, 11'd0, 1'b1);
    tick();

    // Reset while full with a request offered: everything discarded.
    drive(1'b1, 2'b00, 11'd0, 1'b0);
    tick(); tick();
    check("pre_rst_rdy", 32'(bus.in_ready), 32'd0);
    rst = 1'b1;
    tick();
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_rdy",   32'(bus.in_ready),  32'd1);
    check("mid_rst_cnt",   32'(illegal_cnt),   32'd0);
    rst = 1'b0;
    drive(1'b0, 2'b00, 11'd0, 1'b1);
    tick();
    check("post_rst_valid", 32'(bus.out_valid), 32'd0);
    tick();
    check("post_rst_valid2", 32'(bus.out_valid), 32'd0);

    // Random traffic; an offered request is held until the model says it was taken.
    v = 1'b0; a = 2'b00; o = 11'd0;
    for (int i = 0; i < 3000; i++) begin
      if (!v || acc_last) begin
        v = ($urandom_range(0, 3) != 0);
        a = 2'($urandom_range(0, 3));
        case ($urandom_range(0, 5))
          0: o = OPC_ADD;
          1: o = OPC_SUB;
          2: o = OPC_AND;
          3: o = OPC_ORR;
          default: o = 11'($urandom);
        endcase
      end
      rst = ($urandom_range(0, 127) == 0);
      drive(v, a, o, ($urandom_range(0, 2) != 0));
      tick();
      if (rst) v = 1'b0;
    end
    rst = 1'b0;
    drive(1'b0, 2'b00, 11'd0, 1'b1);
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
